// File: rtl/misere_pkg.sv
// Shared encodings for the Wild Misere board engine: symbols, players,
// winner and reject codes, and the control-state enum.
package misere_pkg;

  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_X     = 2'b01;
  localparam logic [1:0] SYM_O     = 2'b10;

  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic [1:0] REJ_NONE     = 2'b00;
  localparam logic [1:0] REJ_BAD      = 2'b01;
  localparam logic [1:0] REJ_OCCUPIED = 2'b10;
  localparam logic [1:0] REJ_OVER     = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    OVER = 2'b10
  } state_t;

  function automatic logic sym_ok(logic [1:0] s);
    return (s == SYM_X) || (s == SYM_O);
  endfunction

endpackage

// File: rtl/misere_board_engine_if.sv
// Move handshake between the keyboard move decoder (master) and the engine (slave).
interface misere_board_engine_if #(parameter int N = 3);
  localparam int POS_W = $clog2(N*N);

  // A move transfers in any cycle where move_valid && move_ready; the engine
  // answers a refused move with a one-cycle move_reject in the following cycle.
  logic             move_valid;
  logic             move_ready;
  logic [POS_W-1:0] move_pos;
  logic [1:0]       move_sym;
  logic             move_reject;
  logic [1:0]       reject_code;

  modport master (output move_valid, move_pos, move_sym,
                  input  move_ready, move_reject, reject_code);
  modport slave  (input  move_valid, move_pos, move_sym,
                  output move_ready, move_reject, reject_code);
endinterface

// File: rtl/misere_line_scanner.sv
// Steps i = 0..N-1 across the four lines through the placed cell and keeps a
// sticky all-match flag per line; line_hit is valid alongside done.
module misere_line_scanner
  import misere_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clear,
  input  logic          start,
  input  logic [1:0]    sym,
  input  logic [1:0]    row_cell,
  input  logic [1:0]    col_cell,
  input  logic [1:0]    diag_cell,
  input  logic [1:0]    anti_cell,
  output logic [IW-1:0] step,
  output logic          done,
  output logic          line_hit
);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic       busy;
    logic [3:0] flags;
    logic [3:0] match;
    logic [3:0] acc;

    // Non-candidate lines arrive as SYM_EMPTY and so can never match a placed symbol.
    assign match    = {row_cell == sym, col_cell == sym, diag_cell == sym, anti_cell == sym};
    assign acc      = ((step == '0) ? 4'hF : flags) & match;
    assign done     = busy && (step == LAST);
    assign line_hit = done && (|acc);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy  <= 1'b0;
            step  <= '0;
            flags <= '0;
        end else if (clear) begin
            busy  <= 1'b0;
            step  <= '0;
            flags <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            step  <= '0;
            flags <= '1;
        end else if (busy) begin
            flags <= acc;
            if (step == LAST) begin
                busy <= 1'b0;
                step <= '0;
            end else begin
                step <= step + 1'b1;
            end
        end
    end

endmodule

// File: rtl/misere_board_engine.sv
// N x N Wild Misere engine: board storage, move validation, turn sequencing
// and the end-of-game decision after an incremental line scan.
module misere_board_engine
  import misere_pkg::*;
#(
  parameter int N     = 3,
  parameter int POS_W = $clog2(N*N)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      new_game,
  misere_board_engine_if.slave      mv,
  input  logic [POS_W-1:0]          rd_pos,
  output logic [1:0]                rd_sym,
  output logic [1:0]                turn,
  output logic                      game_over,
  output logic [1:0]                winner,
  output logic [$clog2(N*N+1)-1:0]  moves_made,
  output state_t                    fsm_state
);
    localparam int unsigned NU    = N;
    localparam int unsigned CELLS = N * N;
    localparam int          IW    = $clog2(N);

    logic [CELLS-1:0][1:0] board;
    state_t                state, state_nx;
    logic [IW-1:0]         row, col, step;
    logic [1:0]            placed_sym, code;
    logic                  scan_start, offer, accept, reject, done, line_hit;
    logic [1:0]            row_cell, col_cell, diag_cell, anti_cell;
    logic                  on_diag, on_anti;

    function automatic logic [POS_W-1:0] cell_at(int unsigned r, int unsigned c);
        return POS_W'(r * NU + c);
    endfunction

    assign mv.move_ready = (state != SCAN);
    assign fsm_state     = state;
    assign rd_sym        = (32'(rd_pos) < CELLS) ? board[rd_pos] : SYM_EMPTY;

    always_comb begin
        code = REJ_NONE;
        if (state == OVER)                                           code = REJ_OVER;
        else if (32'(mv.move_pos) >= CELLS || !sym_ok(mv.move_sym))  code = REJ_BAD;
        else if (board[mv.move_pos] != SYM_EMPTY)                    code = REJ_OCCUPIED;
    end

    // new_game drops any simultaneous handshake outright.
    assign offer  = mv.move_valid && mv.move_ready && !new_game;
    assign accept = offer && (code == REJ_NONE);
    assign reject = offer && (code != REJ_NONE);

    assign on_diag   = (row == col);
    assign on_anti   = (32'(row) + 32'(col)) == (NU - 1);
    assign row_cell  = board[cell_at(32'(row), 32'(step))];
    assign col_cell  = board[cell_at(32'(step), 32'(col))];
    assign diag_cell = on_diag ? board[cell_at(32'(step), 32'(step))] : SYM_EMPTY;
    assign anti_cell = on_anti ? board[cell_at(32'(step), NU - 1 - 32'(step))] : SYM_EMPTY;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SCAN;
            SCAN:    if (done) state_nx = (line_hit || 32'(moves_made) == CELLS) ? OVER : IDLE;
            OVER:    state_nx = OVER;
            default: state_nx = IDLE;
        endcase
        if (new_game) state_nx = IDLE;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            board          <= '0;
            turn           <= P1;
            game_over      <= 1'b0;
            winner         <= WIN_NONE;
            moves_made     <= '0;
            row            <= '0;
            col            <= '0;
            placed_sym     <= SYM_EMPTY;
            scan_start     <= 1'b0;
            mv.move_reject <= 1'b0;
            mv.reject_code <= REJ_NONE;
        end else if (new_game) begin
            board          <= '0;
            turn           <= P1;
            game_over      <= 1'b0;
            winner         <= WIN_NONE;
            moves_made     <= '0;
            scan_start     <= 1'b0;
            mv.move_reject <= 1'b0;
            mv.reject_code <= REJ_NONE;
        end else begin
            // Scanner starts one cycle after the write so step 0 sees the new cell.
            scan_start     <= accept;
            mv.move_reject <= reject;
            if (reject) mv.reject_code <= code;
            if (accept) begin
                board[mv.move_pos] <= mv.move_sym;
                moves_made         <= moves_made + 1'b1;
                row                <= IW'(32'(mv.move_pos) / NU);
                col                <= IW'(32'(mv.move_pos) % NU);
                placed_sym         <= mv.move_sym;
                mv.reject_code     <= REJ_NONE;
            end
            if (state == SCAN && done) begin
                if (line_hit) begin
                    game_over <= 1'b1;
                    winner    <= (turn == P1) ? WIN_P2 : WIN_P1;
                end else if (32'(moves_made) == CELLS) begin
                    game_over <= 1'b1;
                    winner    <= WIN_TIE;
                end else begin
                    turn <= (turn == P1) ? P2 : P1;
                end
            end
        end
    end

    misere_line_scanner #(.N(N)) u_scanner (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (new_game),
        .start     (scan_start),
        .sym       (placed_sym),
        .row_cell  (row_cell),
        .col_cell  (col_cell),
        .diag_cell (diag_cell),
        .anti_cell (anti_cell),
        .step      (step),
        .done      (done),
        .line_hit  (line_hit)
    );

endmodule

// File: tb/tb_misere_board_engine.sv
// Bench for misere_board_engine at N=3 and N=4: directed games plus random
// games checked against a whole-board reference model.
module tb_misere_board_engine;
    import misere_pkg::*;

    int checks = 0;
    int errors = 0;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic new_game = 1'b0;
    always #5 clock = ~clock;

    misere_board_engine_if #(.N(3)) m3 ();
    misere_board_engine_if #(.N(4)) m4 ();

    logic [3:0] rd_pos = '0;
    logic [1:0] rd_sym3, turn3, winner3, rd_sym4, turn4, winner4;
    logic       over3, over4;
    logic [3:0] moves3;
    logic [4:0] moves4;
    state_t     st3, st4;

    misere_board_engine #(.N(3)) dut3 (
        .clock(clock), .resetn(resetn), .new_game(new_game), .mv(m3.slave),
        .rd_pos(rd_pos), .rd_sym(rd_sym3), .turn(turn3), .game_over(over3),
        .winner(winner3), .moves_made(moves3), .fsm_state(st3));

    misere_board_engine #(.N(4)) dut4 (
        .clock(clock), .resetn(resetn), .new_game(new_game), .mv(m4.slave),
        .rd_pos(rd_pos), .rd_sym(rd_sym4), .turn(turn4), .game_over(over4),
        .winner(winner4), .moves_made(moves4), .fsm_state(st4));

    // Reference model: the board as a plain array, rules applied directly.
    logic [1:0] mb [64];
    logic [1:0] m_turn, m_winner;
    bit         m_over;
    int         m_moves;

    task automatic model_reset();
        foreach (mb[i]) mb[i] = 2'b00;
        m_turn = 2'b01; m_winner = 2'b00; m_over = 0; m_moves = 0;
    endtask

    function automatic bit has_line(int n, logic [1:0] s);
        bit a, b, d, e;
        d = 1; e = 1;
        for (int r = 0; r < n; r++) begin
            a = 1; b = 1;
            for (int j = 0; j < n; j++) begin
                if (mb[r*n+j] != s) a = 0;
                if (mb[j*n+r] != s) b = 0;
            end
            if (a || b) return 1;
            if (mb[r*n+r] != s) d = 0;
            if (mb[r*n+(n-1-r)] != s) e = 0;
        end
        return d || e;
    endfunction

    task automatic model_move(int n, int pos, logic [1:0] sym, output logic [1:0] code);
        if (m_over) code = 2'b11;
        else if (pos >= n*n || !(sym == 2'b01 || sym == 2'b10)) code = 2'b01;
        else if (mb[pos] != 2'b00) code = 2'b10;
        else begin
            code = 2'b00;
            mb[pos] = sym;
            m_moves++;
            if (has_line(n, sym)) begin m_over = 1; m_winner = (m_turn == 2'b01) ? 2'b10 : 2'b01; end
            else if (m_moves == n*n) begin m_over = 1; m_winner = 2'b11; end
            else m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
        end
    endtask

    function automatic logic [31:0] f_ready(int n);  return (n == 3) ? 32'(m3.move_ready)  : 32'(m4.move_ready);  endfunction
    function automatic logic [31:0] f_reject(int n); return (n == 3) ? 32'(m3.move_reject) : 32'(m4.move_reject); endfunction
    function automatic logic [31:0] f_code(int n);   return (n == 3) ? 32'(m3.reject_code) : 32'(m4.reject_code); endfunction
    function automatic logic [31:0] f_turn(int n);   return (n == 3) ? 32'(turn3)   : 32'(turn4);   endfunction
    function automatic logic [31:0] f_over(int n);   return (n == 3) ? 32'(over3)   : 32'(over4);   endfunction
    function automatic logic [31:0] f_winner(int n); return (n == 3) ? 32'(winner3) : 32'(winner4); endfunction
    function automatic logic [31:0] f_moves(int n);  return (n == 3) ? 32'(moves3)  : 32'(moves4);  endfunction
    function automatic logic [31:0] f_state(int n);  return (n == 3) ? 32'(st3)     : 32'(st4);     endfunction
    function automatic logic [31:0] f_rdsym(int n);  return (n == 3) ? 32'(rd_sym3) : 32'(rd_sym4); endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int n, bit v, int pos, logic [1:0] sym);
        if (n == 3) begin m3.move_valid = v; m3.move_pos = 4'(pos); m3.move_sym = sym; end
        else        begin m4.move_valid = v; m4.move_pos = 4'(pos); m4.move_sym = sym; end
    endtask

    task automatic check_status(string tag, int n);
        chk({tag, "_turn"},   f_turn(n),   32'(m_turn));
        chk({tag, "_over"},   f_over(n),   32'(m_over));
        chk({tag, "_winner"}, f_winner(n), 32'(m_winner));
        chk({tag, "_moves"},  f_moves(n),  32'(m_moves));
    endtask

    task automatic check_board(string tag, int n);
        for (int i = 0; i < 16; i++) begin
            rd_pos = 4'(i);
            @(negedge clock);
            chk({tag, "_cell"}, f_rdsym(n), (i < n*n) ? 32'(mb[i]) : 32'd0);
        end
    endtask

    task automatic do_new_game();
        @(negedge clock);
        new_game = 1'b1;
        @(posedge clock); #1;
        new_game = 1'b0;
        model_reset();
    endtask

    task automatic do_move(int n, int pos, logic [1:0] sym);
        logic [1:0] code;
        int k, low;
        k = 0;
        while (f_ready(n) == 0 && k < 50) begin @(negedge clock); k++; end
        chk("ready_before_move", f_ready(n), 1);
        model_move(n, pos, sym, code);
        drive(n, 1'b1, pos, sym);
        @(posedge clock); #1;
        drive(n, 1'b0, 0, 2'b00);
        @(negedge clock);
        chk("reject_pulse", f_reject(n), 32'(code != 2'b00));
        if (code != 2'b00) begin
            chk("reject_code", f_code(n), 32'(code));
            @(negedge clock);
            chk("reject_one_cycle", f_reject(n), 0);
        end else begin
            low = 0;
            while (f_ready(n) == 0 && low < 40) begin low++; @(negedge clock); end
            chk("ready_low_cycles", low, n + 1);
        end
        check_status("after_move", n);
    endtask

    task automatic random_game(int n);
        int p, s;
        logic [1:0] sym;
        do_new_game();
        for (int k = 0; k < 40 && !m_over; k++) begin
            p = $urandom_range(0, (n == 3) ? 11 : 15);
            s = $urandom_range(0, 9);
            sym = (s == 0) ? 2'b00 : (s == 1) ? 2'b11 : (s < 6) ? 2'b01 : 2'b10;
            do_move(n, p, sym);
        end
        if (m_over) do_move(n, $urandom_range(0, n*n - 1), 2'b01);
        check_board("random", n);
    endtask

    initial begin
        drive(3, 1'b0, 0, 2'b00);
        drive(4, 1'b0, 0, 2'b00);
        model_reset();
        repeat (2) @(negedge clock);
        chk("reset_ready",  f_ready(3), 1);
        chk("reset_reject", f_reject(3), 0);
        chk("reset_code",   f_code(3), 0);
        chk("reset_state",  f_state(3), 32'(IDLE));
        chk("reset_state4", f_state(4), 32'(IDLE));
        check_status("reset", 3);
        resetn = 1'b1;
        check_board("reset", 3);

        // Row 0 completed by P1 -> P1 loses.
        do_move(3, 0, 2'b01); do_move(3, 4, 2'b10); do_move(3, 1, 2'b01);
        do_move(3, 8, 2'b10); do_move(3, 2, 2'b01);
        chk("row_over", f_over(3), 1);
        chk("row_winner", f_winner(3), 32'(2'b10));
        chk("row_moves", f_moves(3), 5);
        do_move(3, 5, 2'b10);

        // Occupied cell.
        do_new_game();
        do_move(3, 4, 2'b01); do_move(3, 4, 2'b10);
        chk("occ_turn", f_turn(3), 32'(2'b10));
        chk("occ_code", f_code(3), 32'(2'b10));

        // Bad position and bad symbol on an empty board.
        do_new_game();
        do_move(3, 9, 2'b01); do_move(3, 3, 2'b11); do_move(3, 3, 2'b00);
        chk("bad_code", f_code(3), 32'(2'b01));
        check_board("bad", 3);

        // Full board with no line: X O X / X O O / O X X.
        do_new_game();
        do_move(3, 0, 2'b01); do_move(3, 1, 2'b10); do_move(3, 2, 2'b01);
        do_move(3, 4, 2'b10); do_move(3, 3, 2'b01); do_move(3, 5, 2'b10);
        do_move(3, 7, 2'b01); do_move(3, 6, 2'b10); do_move(3, 8, 2'b01);
        chk("tie_winner", f_winner(3), 32'(2'b11));
        do_move(3, 0, 2'b10);
        chk("tie_reject_code", f_code(3), 32'(2'b11));

        // N=4 main diagonal of O; P1 places pos 15 and loses.
        do_new_game();
        do_move(4, 0, 2'b10); do_move(4, 5, 2'b10); do_move(4, 1, 2'b01);
        do_move(4, 10, 2'b10); do_move(4, 2, 2'b01); do_move(4, 3, 2'b01);
        do_move(4, 15, 2'b10);
        chk("diag4_winner", f_winner(4), 32'(2'b10));
        check_board("diag4", 4);

        // new_game in the second SCAN cycle of a winning move.
        do_new_game();
        do_move(3, 0, 2'b01); do_move(3, 4, 2'b10); do_move(3, 1, 2'b01); do_move(3, 8, 2'b10);
        drive(3, 1'b1, 2, 2'b01);
        @(posedge clock); #1;
        drive(3, 1'b0, 0, 2'b00);
        @(posedge clock); #1;
        new_game = 1'b1;
        @(posedge clock); #1;
        new_game = 1'b0;
        model_reset();
        @(negedge clock);
        check_status("abort", 3);
        chk("abort_ready", f_ready(3), 1);
        repeat (6) @(negedge clock);
        check_status("abort_late", 3);
        check_board("abort", 3);

        // Asynchronous reset in the middle of a scan.
        do_move(3, 0, 2'b01); do_move(3, 4, 2'b10);
        drive(3, 1'b1, 1, 2'b01);
        @(posedge clock); #1;
        drive(3, 1'b0, 0, 2'b00);
        @(negedge clock);
        chk("pre_reset_state", f_state(3), 32'(SCAN));
        resetn = 1'b0;
        #1;
        model_reset();
        check_status("async_reset", 3);
        chk("async_reset_ready", f_ready(3), 1);
        check_board("async_reset", 3);
        resetn = 1'b1;

        for (int g = 0; g < 4; g++) random_game(3);
        for (int g = 0; g < 3; g++) random_game(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
